// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
//   Program-loading front end for the n1 CPU core. Receives a framed byte
//   stream over a valid/ready handshake, packs pairs of bytes (high byte first)
//   into 16-bit words, and writes them sequentially into the CPU RAM write port.
//   Once the whole frame has been received, a trailing 8-bit checksum is
//   verified. The CPU is held in reset from load_start until a frame loads
//   cleanly.
//
//   Frame: 0xA5, LEN, {hi,lo} x LEN, CHK
//          CHK = (LEN + sum of all data bytes) mod 256
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   load_start            one-cycle pulse, begins or restarts a load
//   rx_data/rx_valid      incoming byte stream
//   rx_ready              a byte is accepted on a cycle with rx_valid && rx_ready
//   ram_we/addr/wdata     RAM write port, one strobe per assembled word
//   cpu_hold              CPU reset request, high while loading or after failure
//   busy                  FSM is inside a frame (SYNC..CHECK)
//   done                  level, last frame loaded with a good checksum
//   error/err_code        level, last frame failed; 1=length 2=checksum 3=timeout
// -----------------------------------------------------------------------------
module prog_loader #(
    parameter int ADDR_BITS   = 7,
    parameter int RAM_WORDS   = 127,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_start,
    input  logic [7:0]           rx_data,
    input  logic                 rx_valid,
    output logic                 rx_ready,
    output logic                 ram_we,
    output logic [ADDR_BITS-1:0] ram_addr,
    output logic [15:0]          ram_wdata,
    output logic                 cpu_hold,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [1:0]           err_code
);

    localparam int          TMO_W     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [8:0]  MAX_LEN   = 9'(RAM_WORDS);
    localparam logic [7:0]  SYNC_BYTE = 8'hA5;

    localparam logic [1:0]  E_LEN = 2'd1;
    localparam logic [1:0]  E_CHK = 2'd2;
    localparam logic [1:0]  E_TMO = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_LEN,
        S_HI,
        S_LO,
        S_CHECK,
        S_DONE,
        S_ERR
    } state_t;

    state_t                 state;
    logic [7:0]             len_q;      // word count of current frame
    logic [7:0]             hi_q;       // high byte of the word being assembled
    logic [7:0]             csum;       // running 8-bit modular checksum
    logic [ADDR_BITS-1:0]   widx;       // index of the next word to write
    logic [TMO_W-1:0]       tmo_cnt;    // idle cycles since last accept / state entry

    logic                   in_frame;
    logic                   tmo_state;
    logic                   accept;
    logic                   last_word;
    logic                   len_bad;

    // Ready and busy are pure decodes of the state register, so they stay
    // high back-to-back through a frame and the stream never stalls.
    assign in_frame  = (state == S_SYNC) || (state == S_LEN) || (state == S_HI) ||
                       (state == S_LO)   || (state == S_CHECK);
    assign tmo_state = (state == S_LEN) || (state == S_HI) ||
                       (state == S_LO)  || (state == S_CHECK);
    assign rx_ready  = in_frame;
    assign busy      = in_frame;
    assign accept    = rx_valid && rx_ready;

    // Compared at 9 bits so widx + 1 can reach LEN without overflowing.
    assign last_word = (9'(len_q) == (9'(widx) + 9'd1));
    assign len_bad   = (rx_data == 8'd0) || (9'(rx_data) > MAX_LEN);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            len_q     <= '0;
            hi_q      <= '0;
            csum      <= '0;
            widx      <= '0;
            tmo_cnt   <= '0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            cpu_hold  <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            err_code  <= '0;
        end else begin
            // Write strobe is a single-cycle pulse; a write registered on the
            // previous cycle still lands even if load_start arrives now.
            ram_we <= 1'b0;

            if (load_start) begin
                // Restart wins over everything, including a coincident byte.
                state    <= S_SYNC;
                cpu_hold <= 1'b1;
                done     <= 1'b0;
                error    <= 1'b0;
                err_code <= '0;
                tmo_cnt  <= '0;
            end else begin
                // Idle watchdog: cleared by any accepted byte, and outside the
                // counting states, so every state entry starts from zero.
                if (tmo_state && !accept) begin
                    if (tmo_cnt == TMO_LAST) begin
                        state    <= S_ERR;
                        error    <= 1'b1;
                        err_code <= E_TMO;
                        tmo_cnt  <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end else begin
                    tmo_cnt <= '0;
                end

                if (accept) begin
                    case (state)
                        S_SYNC: begin
                            // Anything other than the sync byte is dropped.
                            if (rx_data == SYNC_BYTE) state <= S_LEN;
                        end

                        S_LEN: begin
                            if (len_bad) begin
                                state    <= S_ERR;
                                error    <= 1'b1;
                                err_code <= E_LEN;
                            end else begin
                                len_q <= rx_data;
                                csum  <= rx_data;
                                widx  <= '0;
                                state <= S_HI;
                            end
                        end

                        S_HI: begin
                            hi_q  <= rx_data;
                            csum  <= csum + rx_data;
                            state <= S_LO;
                        end

                        S_LO: begin
                            csum      <= csum + rx_data;
                            ram_we    <= 1'b1;
                            ram_addr  <= widx;
                            ram_wdata <= {hi_q, rx_data};
                            widx      <= widx + 1'b1;
                            state     <= last_word ? S_CHECK : S_HI;
                        end

                        S_CHECK: begin
                            if (rx_data == csum) begin
                                state    <= S_DONE;
                                done     <= 1'b1;
                                cpu_hold <= 1'b0;
                            end else begin
                                state    <= S_ERR;
                                error    <= 1'b1;
                                err_code <= E_CHK;
                            end
                        end

                        default: ;
                    endcase
                end
            end
        end
    end

endmodule
